// File: rtl/cpu5_mem_arbiter.sv
// cpu5 single-port memory arbiter: LSU-priority with IFU anti-starvation.
// Sequences one access at a time through a mem_req/mem_ready handshake.
module cpu5_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_gnt,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_req,
  input  logic          lsu_we,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    IFU_BUSY,
    LSU_BUSY
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       lsu_win;
  logic       ifu_win;

  // LSU wins unless the IFU has lost STARVE_MAX contested rounds in a row
  assign lsu_win = lsu_req & (~ifu_req | (starve_cnt < SMAX));
  assign ifu_win = ifu_req & ~lsu_win;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ifu_gnt    <= 1'b0;
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= '0;
      lsu_gnt    <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      ifu_gnt    <= 1'b0;
      ifu_rvalid <= 1'b0;
      lsu_gnt    <= 1'b0;
      lsu_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            lsu_win: begin
              state     <= LSU_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= lsu_we;
              mem_addr  <= lsu_addr;
              mem_wdata <= lsu_wdata;
              lsu_gnt   <= 1'b1;
              busy      <= 1'b1;
              if (ifu_req)
                starve_cnt <= starve_cnt + 4'd1;
            end
            ifu_win: begin
              state      <= IFU_BUSY;
              mem_req    <= 1'b1;
              mem_we     <= 1'b0;
              mem_addr   <= ifu_addr;
              mem_wdata  <= '0;
              ifu_gnt    <= 1'b1;
              busy       <= 1'b1;
              starve_cnt <= '0;
            end
            default: ;
          endcase
        end
        IFU_BUSY: begin
          if (mem_ready) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            ifu_rvalid <= 1'b1;
            ifu_rdata  <= mem_rdata;
          end
        end
        LSU_BUSY: begin
          if (mem_ready) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            busy       <= 1'b0;
            lsu_rvalid <= 1'b1;
            if (!mem_we)
              lsu_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu5_mem_arbiter.sv
// Bench for cpu5_mem_arbiter: directed cases plus random traffic
// checked cycle by cycle against a transaction-level ownership model.
module tb_cpu5_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          ifu_req = 1'b0;
  logic [AW-1:0] ifu_addr = '0;
  logic          ifu_gnt, ifu_rvalid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req = 1'b0;
  logic          lsu_we = 1'b0;
  logic [AW-1:0] lsu_addr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          lsu_gnt, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  cpu5_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr),
    .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model: who owns the port (0 none, 1 ifu, 2 lsu) and contested LSU wins
  int            m_own;
  int            m_cnt;
  logic          e_ifu_gnt, e_ifu_rvalid, e_lsu_gnt, e_lsu_rvalid;
  logic          e_mem_req, e_mem_we, e_busy;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_ifu_rdata, e_lsu_rdata;
  int            gq[$];

  task automatic model_reset();
    m_own = 0; m_cnt = 0;
    e_ifu_gnt = 0; e_ifu_rvalid = 0; e_lsu_gnt = 0; e_lsu_rvalid = 0;
    e_mem_req = 0; e_mem_we = 0; e_busy = 0;
    e_mem_addr = '0; e_mem_wdata = '0;
    e_ifu_rdata = '0; e_lsu_rdata = '0;
  endtask

  task automatic model_step();
    e_ifu_gnt = 0; e_ifu_rvalid = 0; e_lsu_gnt = 0; e_lsu_rvalid = 0;
    if (m_own == 0) begin
      if (lsu_req && (!ifu_req || m_cnt < SM)) begin
        m_own = 2; e_lsu_gnt = 1; e_mem_req = 1;
        e_mem_we = lsu_we; e_mem_addr = lsu_addr; e_mem_wdata = lsu_wdata;
        if (ifu_req) m_cnt = m_cnt + 1;
      end else if (ifu_req) begin
        m_own = 1; e_ifu_gnt = 1; e_mem_req = 1;
        e_mem_we = 0; e_mem_addr = ifu_addr; e_mem_wdata = '0;
        m_cnt = 0;
      end
    end else if (mem_ready) begin
      if (m_own == 1) begin
        e_ifu_rvalid = 1; e_ifu_rdata = mem_rdata;
      end else begin
        e_lsu_rvalid = 1;
        if (!e_mem_we) e_lsu_rdata = mem_rdata;
      end
      e_mem_req = 0; m_own = 0;
    end
    e_busy = (m_own != 0);
  endtask

  task automatic check_outs(input string ph);
    chk({ph, ".ifu_gnt"}, ifu_gnt, e_ifu_gnt);
    chk({ph, ".ifu_rvalid"}, ifu_rvalid, e_ifu_rvalid);
    chk({ph, ".ifu_rdata"}, ifu_rdata, e_ifu_rdata);
    chk({ph, ".lsu_gnt"}, lsu_gnt, e_lsu_gnt);
    chk({ph, ".lsu_rvalid"}, lsu_rvalid, e_lsu_rvalid);
    chk({ph, ".lsu_rdata"}, lsu_rdata, e_lsu_rdata);
    chk({ph, ".mem_req"}, mem_req, e_mem_req);
    chk({ph, ".mem_we"}, mem_we, e_mem_we);
    chk({ph, ".mem_addr"}, mem_addr, e_mem_addr);
    chk({ph, ".mem_wdata"}, mem_wdata, e_mem_wdata);
    chk({ph, ".busy"}, busy, e_busy);
    if (ifu_gnt) gq.push_back(1);
    if (lsu_gnt) gq.push_back(2);
  endtask

  // one clock: predict, advance, compare; requesters drop req once granted
  task automatic tick(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_outs(ph);
    if (ifu_gnt) ifu_req = 0;
    if (lsu_gnt) lsu_req = 0;
  endtask

  initial begin
    model_reset();

    // reset with both requests pending
    ifu_req = 1; ifu_addr = 32'h40;
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h80;
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("rst");
    resetn = 1;
    mem_ready = 1; mem_rdata = 32'h1111_2222;
    tick("rst_rel");
    chk("rst_first_lsu_gnt", lsu_gnt, 1);
    repeat (4) tick("rst_drain");

    // single zero-wait fetch
    mem_ready = 1; mem_rdata = 32'h0050_0093;
    ifu_req = 1; ifu_addr = 32'h100;
    tick("fetch_g");
    chk("fetch_gnt", ifu_gnt, 1);
    chk("fetch_addr", mem_addr, 32'h100);
    chk("fetch_we", mem_we, 0);
    tick("fetch_r");
    chk("fetch_rvalid", ifu_rvalid, 1);
    chk("fetch_rdata", ifu_rdata, 32'h0050_0093);
    mem_ready = 0;
    tick("fetch_idle");

    // store with 3 wait states
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h200; lsu_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hAAAA_5555;
    tick("st_g");
    chk("st_gnt", lsu_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      tick("st_wait");
      chk("st_hold_req", mem_req, 1);
      chk("st_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("st_hold_addr", mem_addr, 32'h200);
    end
    mem_ready = 1;
    tick("st_done");
    chk("st_rvalid", lsu_rvalid, 1);
    chk("st_rdata_kept", lsu_rdata, 32'h1111_2222);
    mem_ready = 0;
    tick("st_idle");
    chk("st_rvalid_once", lsu_rvalid, 0);

    // contention, zero-wait memory
    gq.delete();
    mem_ready = 1; lsu_we = 0;
    for (int i = 0; i < 30; i++) begin
      ifu_req = 1; ifu_addr = 32'h1000 + i;
      lsu_req = 1; lsu_addr = 32'h2000 + i;
      mem_rdata = $urandom;
      tick("cont");
    end
    ifu_req = 0; lsu_req = 0;
    repeat (2) tick("cont_drain");
    chk("cont_ngrants", gq.size(), 15);
    for (int i = 0; i < gq.size(); i++)
      chk($sformatf("cont_order%0d", i), gq[i], (i % 5 == 4) ? 1 : 2);

    // reset during a stalled load
    mem_ready = 0;
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h300;
    tick("mrst_g");
    tick("mrst_w");
    resetn = 0;
    #1;
    model_reset();
    check_outs("mrst_async");
    chk("mrst_mem_req", mem_req, 0);
    mem_ready = 1;
    @(posedge clk);
    #1;
    resetn = 1;
    mem_ready = 0;
    repeat (3) tick("mrst_after");

    // spurious ready while idle
    mem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      mem_rdata = $urandom;
      tick("spur");
      chk("spur_busy", busy, 0);
    end
    mem_ready = 0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!ifu_req && $urandom_range(0, 2) == 0) begin
        ifu_req = 1; ifu_addr = $urandom;
      end
      if (!lsu_req && $urandom_range(0, 2) == 0) begin
        lsu_req = 1; lsu_we = $urandom_range(0, 1) == 1;
        lsu_addr = $urandom; lsu_wdata = $urandom;
      end
      mem_ready = $urandom_range(0, 4) < 2;
      mem_rdata = $urandom;
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
